// File: rtl/controle_tentativas_pkg.sv
// +--------------------------------------------------------------------+
// | controle_pkg: shared state encoding and attempt width for the safe |
// | attempt controller.                 Revision: 1.0                  |
// +--------------------------------------------------------------------+
`default_nettype none

package controle_pkg;

  localparam int C_TENTATIVA_W = 4;

  localparam logic [1:0] OCIOSO    = 2'd0;
  localparam logic [1:0] AVALIA    = 2'd1;
  localparam logic [1:0] ABERTO    = 2'd2;
  localparam logic [1:0] BLOQUEADO = 2'd3;

  typedef enum logic [1:0] {
    S_OCIOSO    = OCIOSO,
    S_AVALIA    = AVALIA,
    S_ABERTO    = ABERTO,
    S_BLOQUEADO = BLOQUEADO
  } estado_t;

endpackage

`default_nettype wire

// File: rtl/controle_tentativas_sincroniza_botao.sv
// +--------------------------------------------------------------------+
// | sincroniza_botao: 2-flop synchroniser, optional debounce           |
// | (CONTROLE_TENTATIVAS_DEBOUNCE_EN) and rising-edge press pulse.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module sincroniza_botao
`ifdef CONTROLE_TENTATIVAS_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CICLOS = 500_000
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic press
);

  logic r_sync1;
  logic r_sync2;
  logic r_anterior;
  logic w_nivel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_anterior <= 1'b0;
    end else begin
      r_sync1    <= i_btn;
      r_sync2    <= r_sync1;
      r_anterior <= w_nivel;
    end
  end

`ifdef CONTROLE_TENTATIVAS_DEBOUNCE_EN
  localparam int                 C_CNT_W   = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_FIM = C_CNT_W'(DEBOUNCE_CICLOS - 1);

  logic [C_CNT_W-1:0] r_cnt;
  logic               r_estavel;

  // The counter restarts whenever the synchronised level agrees with the
  // debounced one, so only an uninterrupted run can flip the level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_estavel <= 1'b0;
    end else if (r_sync2 == r_estavel) begin
      r_cnt <= '0;
    end else if (r_cnt == C_CNT_FIM) begin
      r_cnt     <= '0;
      r_estavel <= r_sync2;
    end else begin
      r_cnt <= r_cnt + C_CNT_W'(1);
    end
  end

  assign w_nivel = r_estavel;
`else
  assign w_nivel = r_sync2;
`endif

  assign press = w_nivel & ~r_anterior;

endmodule

`default_nettype wire

// File: rtl/controle_tentativas.sv
// +--------------------------------------------------------------------+
// | controle_tentativas: captures the safe attempt, tracks failures and|
// | enforces a timed lockout. Optional CONTROLE_TENTATIVAS_DEBOUNCE_EN.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module controle_tentativas
  import controle_pkg::*;
#(
  parameter int MAX_FALHAS      = 3,
  parameter int BLOQUEIO_CICLOS = 50_000_000,
`ifdef CONTROLE_TENTATIVAS_DEBOUNCE_EN
  parameter int DEBOUNCE_CICLOS = 500_000,
`endif
  parameter int FALHAS_W        = $clog2(MAX_FALHAS + 1)
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [C_TENTATIVA_W-1:0] chaves,
  input  logic                     btn_confirma,
  input  logic                     igual,
  output logic [C_TENTATIVA_W-1:0] tentativa,
  output logic                     tentativa_valida,
  output logic                     aberto,
  output logic                     bloqueado,
  output logic [FALHAS_W-1:0]      falhas
);

  localparam int                   C_TIMER_W   = (BLOQUEIO_CICLOS > 1) ? $clog2(BLOQUEIO_CICLOS) : 1;
  localparam logic [C_TIMER_W-1:0] C_TIMER_INI = C_TIMER_W'(BLOQUEIO_CICLOS - 1);
  localparam logic [FALHAS_W:0]    C_MAX       = (FALHAS_W + 1)'(MAX_FALHAS);

  estado_t                  r_estado,    w_estado_prox;
  logic [C_TENTATIVA_W-1:0] r_tentativa, w_tentativa_prox;
  logic                     r_valida,    w_valida_prox;
  logic                     r_aberto,    w_aberto_prox;
  logic                     r_bloq,      w_bloq_prox;
  logic [FALHAS_W-1:0]      r_falhas,    w_falhas_prox;
  logic [C_TIMER_W-1:0]     r_timer,     w_timer_prox;
  logic [FALHAS_W:0]        w_falhas_inc;
  logic                     w_press;

  sincroniza_botao
`ifdef CONTROLE_TENTATIVAS_DEBOUNCE_EN
  #(
    .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS)
  )
`endif
  u_sincroniza_botao (
    .clk   (clk),
    .rst   (rst),
    .i_btn (btn_confirma),
    .press (w_press)
  );

  // One extra bit so the MAX_FALHAS comparison cannot wrap.
  assign w_falhas_inc = {1'b0, r_falhas} + (FALHAS_W + 1)'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado    <= S_OCIOSO;
      r_tentativa <= '0;
      r_valida    <= 1'b0;
      r_aberto    <= 1'b0;
      r_bloq      <= 1'b0;
      r_falhas    <= '0;
      r_timer     <= '0;
    end else begin
      r_estado    <= w_estado_prox;
      r_tentativa <= w_tentativa_prox;
      r_valida    <= w_valida_prox;
      r_aberto    <= w_aberto_prox;
      r_bloq      <= w_bloq_prox;
      r_falhas    <= w_falhas_prox;
      r_timer     <= w_timer_prox;
    end
  end

  always_comb begin
    w_estado_prox    = r_estado;
    w_tentativa_prox = r_tentativa;
    w_valida_prox    = r_valida;
    w_aberto_prox    = r_aberto;
    w_bloq_prox      = r_bloq;
    w_falhas_prox    = r_falhas;
    w_timer_prox     = r_timer;

    case (r_estado)
      S_OCIOSO: begin
        if (w_press) begin
          w_tentativa_prox = chaves;
          w_valida_prox    = 1'b1;
          w_estado_prox    = S_AVALIA;
        end
      end
      // Single cycle: the external comparator sees the new attempt first.
      S_AVALIA: begin
        if (igual) begin
          w_falhas_prox = '0;
          w_aberto_prox = 1'b1;
          w_estado_prox = S_ABERTO;
        end else if (w_falhas_inc < C_MAX) begin
          w_falhas_prox = w_falhas_inc[FALHAS_W-1:0];
          w_estado_prox = S_OCIOSO;
        end else begin
          w_falhas_prox = C_MAX[FALHAS_W-1:0];
          w_bloq_prox   = 1'b1;
          w_timer_prox  = C_TIMER_INI;
          w_estado_prox = S_BLOQUEADO;
        end
      end
      S_ABERTO: begin
        if (w_press) begin
          w_aberto_prox    = 1'b0;
          w_tentativa_prox = '0;
          w_valida_prox    = 1'b0;
          w_estado_prox    = S_OCIOSO;
        end
      end
      S_BLOQUEADO: begin
        if (r_timer == '0) begin
          w_bloq_prox   = 1'b0;
          w_falhas_prox = '0;
          w_estado_prox = S_OCIOSO;
        end else begin
          w_timer_prox = r_timer - C_TIMER_W'(1);
        end
      end
      default: begin
        w_estado_prox = S_OCIOSO;
      end
    endcase
  end

  assign tentativa        = r_tentativa;
  assign tentativa_valida = r_valida;
  assign aberto           = r_aberto;
  assign bloqueado        = r_bloq;
  assign falhas           = r_falhas;

endmodule

`default_nettype wire
